// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory: funct3 width codes, FSM
// states and the byte-lane steering / load extension helpers.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Byte enables for a store of the given width at the given low address bits.
    function automatic logic [3:0] lane_mask(input logic [2:0] funct3,
                                             input logic [1:0] addr_lo);
        logic [3:0] mask;
        mask = 4'b0000;
        case (funct3)
            F3_B:    mask = 4'b0001 << addr_lo;
            F3_H:    mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            F3_W:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Replicate right-aligned store data so every candidate lane carries it.
    function automatic logic [31:0] store_lanes(input logic [2:0]  funct3,
                                                input logic [31:0] wdata);
        logic [31:0] lanes;
        lanes = wdata;
        case (funct3)
            F3_B:    lanes = {4{wdata[7:0]}};
            F3_H:    lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

    // Pick the addressed byte/halfword out of a word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [2:0]  funct3,
                                                 input logic [1:0]  addr_lo,
                                                 input logic [31:0] word);
        logic [7:0]  sel_b;
        logic [15:0] sel_h;
        logic [31:0] result;
        sel_b  = word[{addr_lo, 3'b000} +: 8];
        sel_h  = addr_lo[1] ? word[31:16] : word[15:0];
        result = word;
        case (funct3)
            F3_B:    result = {{24{sel_b[7]}}, sel_b};
            F3_H:    result = {{16{sel_h[15]}}, sel_h};
            F3_BU:   result = {24'h000000, sel_b};
            F3_HU:   result = {16'h0000, sel_h};
            default: result = word;
        endcase
        return result;
    endfunction

    // Width/alignment/direction legality; address range is checked by the caller.
    function automatic logic funct3_fault(input logic       write,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b1;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = addr_lo[0];
            F3_W:    bad = (addr_lo != 2'b00);
            F3_BU:   bad = write;
            F3_HU:   bad = write | addr_lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32 storage with one byte-enabled write port, an asynchronous
// read of the same index, and a synchronous clear on reset.
module dmem_array #(
    parameter  int DEPTH_WORDS = 1024,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: clearing every word on reset means this array cannot map onto a
    // RAM macro; the clear is part of the block's contract, so keep it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (be[lane]) begin
                    mem[idx][8*lane +: 8] <= wdata[8*lane +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data memory controller: request/response handshake, access latency
// counter, fault detection, lane steering and registered response.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_req_valid,
    output logic        out_req_ready,
    input  logic        in_req_write,
    input  logic [31:0] in_req_addr,
    input  logic [31:0] in_req_wdata,
    input  logic [2:0]  in_req_funct3,
    output logic        out_resp_valid,
    input  logic        in_resp_ready,
    output logic [31:0] out_resp_data,
    output logic        out_resp_fault
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;

    logic          req_write;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [2:0]    req_funct3;
    logic [31:0]   resp_data;
    logic          resp_fault;

    logic          accept;
    logic          access;
    logic          in_range;
    logic          fault;
    logic          array_we;
    logic [3:0]    array_be;
    logic [31:0]   array_rdata;

    assign out_req_ready  = (state == IDLE);
    assign out_resp_valid = (state == RESP);
    assign out_resp_data  = resp_data;
    assign out_resp_fault = resp_fault;

    assign accept   = in_req_valid && out_req_ready;
    // The single edge that enters RESP is the only one that touches the array.
    assign access   = (state == BUSY) && (cnt == '0);

    assign in_range = (req_addr[31:AW+2] == '0);
    assign fault    = !in_range || funct3_fault(req_write, req_funct3, req_addr[1:0]);
    assign array_we = access && req_write && !fault;
    assign array_be = lane_mask(req_funct3, req_addr[1:0]);

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (array_we),
        .be    (array_be),
        .idx   (req_addr[AW+1:2]),
        .wdata (store_lanes(req_funct3, req_wdata)),
        .rdata (array_rdata)
    );

    // NOTE: state_next gets its default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)        state_next = BUSY;
            BUSY:    if (cnt == '0)     state_next = RESP;
            RESP:    if (in_resp_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments everywhere here, so every register sees
    // the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            req_write  <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_funct3 <= '0;
            resp_data  <= '0;
            resp_fault <= 1'b0;
        end else begin
            state <= state_next;

            if (accept) begin
                req_write  <= in_req_write;
                req_addr   <= in_req_addr;
                req_wdata  <= in_req_wdata;
                req_funct3 <= in_req_funct3;
                cnt        <= CNT_LOAD;
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            if (access) begin
                resp_fault <= fault;
                resp_data  <= (fault || req_write)
                              ? '0
                              : load_extract(req_funct3, req_addr[1:0], array_rdata);
            end else if (state == RESP && in_resp_ready) begin
                resp_fault <= 1'b0;
                resp_data  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (latency 1 and 4) checked against a
// byte-array reference model of the load/store rules.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int DEPTH  = 64;
    localparam int BUDGET = 50;

    logic        clk;
    logic        reset;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [2:0]  req_funct3 [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_data  [2];
    logic        resp_fault [2];

    logic [7:0]  mem_b [2][4*DEPTH];
    int          checks;
    int          errors;

    dmem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_l1 (
        .clk            (clk),
        .reset          (reset),
        .in_req_valid   (req_valid[0]),
        .out_req_ready  (req_ready[0]),
        .in_req_write   (req_write[0]),
        .in_req_addr    (req_addr[0]),
        .in_req_wdata   (req_wdata[0]),
        .in_req_funct3  (req_funct3[0]),
        .out_resp_valid (resp_valid[0]),
        .in_resp_ready  (resp_ready[0]),
        .out_resp_data  (resp_data[0]),
        .out_resp_fault (resp_fault[0])
    );

    dmem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) dut_l4 (
        .clk            (clk),
        .reset          (reset),
        .in_req_valid   (req_valid[1]),
        .out_req_ready  (req_ready[1]),
        .in_req_write   (req_write[1]),
        .in_req_addr    (req_addr[1]),
        .in_req_wdata   (req_wdata[1]),
        .in_req_funct3  (req_funct3[1]),
        .out_resp_valid (resp_valid[1]),
        .in_resp_ready  (resp_ready[1]),
        .out_resp_data  (resp_data[1]),
        .out_resp_fault (resp_fault[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic void model_clear();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4*DEPTH; i++)
                mem_b[d][i] = 8'h00;
    endfunction

    // Reference: memory as a flat little-endian byte array.
    function automatic void model(input int d, input bit wr, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [2:0] f3,
                                  output logic [31:0] data, output logic flt);
        int          size;
        bit          uns;
        bit          legal;
        bit          misal;
        logic [31:0] value;
        size = 0; uns = 0; legal = 1; misal = 0;
        case (f3)
            3'd0: size = 1;
            3'd1: size = 2;
            3'd2: size = 4;
            3'd4: begin size = 1; uns = 1; end
            3'd5: begin size = 2; uns = 1; end
            default: legal = 0;
        endcase
        if (legal) misal = (addr % size) != 0;
        flt  = !legal || (wr && uns) || misal || (addr >= 4*DEPTH);
        data = 32'h0;
        if (!flt) begin
            if (wr) begin
                for (int i = 0; i < size; i++) mem_b[d][addr + i] = wdata[8*i +: 8];
            end else begin
                value = 32'h0;
                for (int i = 0; i < size; i++) value = value | (32'(mem_b[d][addr + i]) << (8*i));
                if (!uns && size < 4 && value[8*size - 1]) value = value | (32'hFFFF_FFFF << (8*size));
                data = value;
            end
        end
    endfunction

    task automatic xact(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        output logic [31:0] data, output logic flt, output int lat);
        int wait_cyc;
        @(negedge clk);
        req_valid[d]  = 1'b1;
        req_write[d]  = wr;
        req_addr[d]   = addr;
        req_wdata[d]  = wdata;
        req_funct3[d] = f3;
        wait_cyc = 0;
        while (req_ready[d] !== 1'b1 && wait_cyc < BUDGET) begin
            @(negedge clk);
            wait_cyc++;
        end
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        lat = 0;
        while (resp_valid[d] !== 1'b1 && lat < BUDGET) begin
            @(posedge clk); #1;
            lat++;
        end
        data = resp_data[d];
        flt  = resp_fault[d];
        resp_ready[d] = 1'b1;
        @(posedge clk); #1;
        resp_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            checks++; if (req_ready[d] !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d]: got %b want 1", d, req_ready[d]); end
            checks++; if (resp_valid[d] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %b want 0", d, resp_valid[d]); end
            checks++; if (resp_data[d] !== 32'h0) begin errors++; $display("FAIL reset_data[%0d]: got %h want 0", d, resp_data[d]); end
            checks++; if (resp_fault[d] !== 1'b0) begin errors++; $display("FAIL reset_fault[%0d]: got %b want 0", d, resp_fault[d]); end
        end
    endtask

    task automatic test_word_l1();
        logic [31:0] d_got, d_exp;
        logic        f_got, f_exp;
        int          lat;
        model(0, 1, 32'h10, 32'hDEADBEEF, F3_W, d_exp, f_exp);
        xact(0, 1, 32'h10, 32'hDEADBEEF, F3_W, d_got, f_got, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL sw_latency: got %0d want 1", lat); end
        checks++; if (f_got !== 1'b0) begin errors++; $display("FAIL sw_fault: got %b want 0", f_got); end
        checks++; if (d_got !== 32'h0) begin errors++; $display("FAIL sw_data: got %h want 0", d_got); end
        model(0, 0, 32'h10, 32'h0, F3_W, d_exp, f_exp);
        xact(0, 0, 32'h10, 32'h0, F3_W, d_got, f_got, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL lw_latency: got %0d want 1", lat); end
        checks++; if (d_got !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", d_got); end
        checks++; if (f_got !== 1'b0) begin errors++; $display("FAIL lw_fault: got %b want 0", f_got); end
    endtask

    task automatic test_steering();
        logic [31:0] d_got, d_exp;
        logic        f_got, f_exp;
        int          lat;
        model(0, 1, 32'h13, 32'hAAAAAA80, F3_B, d_exp, f_exp);
        xact(0, 1, 32'h13, 32'hAAAAAA80, F3_B, d_got, f_got, lat);
        checks++; if (f_got !== 1'b0) begin errors++; $display("FAIL sb_fault: got %b want 0", f_got); end
        model(0, 0, 32'h13, 32'h0, F3_B, d_exp, f_exp);
        xact(0, 0, 32'h13, 32'h0, F3_B, d_got, f_got, lat);
        checks++; if (d_got !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data: got %h want ffffff80", d_got); end
        model(0, 0, 32'h13, 32'h0, F3_BU, d_exp, f_exp);
        xact(0, 0, 32'h13, 32'h0, F3_BU, d_got, f_got, lat);
        checks++; if (d_got !== 32'h00000080) begin errors++; $display("FAIL lbu_data: got %h want 00000080", d_got); end
        // Word is now 0x80ADBEEF; the upper halfword 0x80AD sign-extends.
        model(0, 0, 32'h12, 32'h0, F3_H, d_exp, f_exp);
        xact(0, 0, 32'h12, 32'h0, F3_H, d_got, f_got, lat);
        checks++; if (d_got !== 32'hFFFF80AD) begin errors++; $display("FAIL lh_data: got %h want ffff80ad", d_got); end
        checks++; if (d_got !== d_exp) begin errors++; $display("FAIL lh_model: got %h want %h", d_got, d_exp); end
        model(0, 0, 32'h12, 32'h0, F3_HU, d_exp, f_exp);
        xact(0, 0, 32'h12, 32'h0, F3_HU, d_got, f_got, lat);
        checks++; if (d_got !== 32'h000080AD) begin errors++; $display("FAIL lhu_data: got %h want 000080ad", d_got); end
    endtask

    task automatic test_faults();
        logic [31:0] d_got, d_exp;
        logic        f_got, f_exp;
        int          lat;
        xact(0, 0, 32'h11, 32'h0, F3_W, d_got, f_got, lat);
        checks++; if (f_got !== 1'b1) begin errors++; $display("FAIL lw_misal_fault: got %b want 1", f_got); end
        checks++; if (d_got !== 32'h0) begin errors++; $display("FAIL lw_misal_data: got %h want 0", d_got); end
        model(0, 1, 32'h20, 32'hCAFEF00D, F3_W, d_exp, f_exp);
        xact(0, 1, 32'h20, 32'hCAFEF00D, F3_W, d_got, f_got, lat);
        xact(0, 1, 32'h21, 32'h00001234, F3_H, d_got, f_got, lat);
        checks++; if (f_got !== 1'b1) begin errors++; $display("FAIL sh_misal_fault: got %b want 1", f_got); end
        xact(0, 0, 32'h20, 32'h0, F3_W, d_got, f_got, lat);
        checks++; if (d_got !== 32'hCAFEF00D) begin errors++; $display("FAIL sh_misal_nowrite: got %h want cafef00d", d_got); end
        xact(0, 0, 4*DEPTH, 32'h0, F3_W, d_got, f_got, lat);
        checks++; if (f_got !== 1'b1) begin errors++; $display("FAIL range_fault: got %b want 1", f_got); end
        checks++; if (d_got !== 32'h0) begin errors++; $display("FAIL range_data: got %h want 0", d_got); end
        xact(0, 0, 32'h20, 32'h0, 3'b011, d_got, f_got, lat);
        checks++; if (f_got !== 1'b1) begin errors++; $display("FAIL f3_011_fault: got %b want 1", f_got); end
        xact(0, 1, 32'h20, 32'h000000FF, F3_BU, d_got, f_got, lat);
        checks++; if (f_got !== 1'b1) begin errors++; $display("FAIL store_bu_fault: got %b want 1", f_got); end
        xact(0, 0, 32'h20, 32'h0, F3_W, d_got, f_got, lat);
        checks++; if (d_got !== 32'hCAFEF00D) begin errors++; $display("FAIL store_bu_nowrite: got %h want cafef00d", d_got); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d_got, d_exp, first_d, seed;
        logic        f_got, f_exp;
        int          lat;
        seed = $urandom;
        model(1, 1, 32'h30, seed, F3_W, d_exp, f_exp);
        xact(1, 1, 32'h30, seed, F3_W, d_got, f_got, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL l4_latency: got %0d want 4", lat); end
        model(1, 0, 32'h30, 32'h0, F3_W, d_exp, f_exp);
        @(negedge clk);
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h30; req_funct3[1] = F3_W;
        checks++; if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL bp_ready_idle: got %b want 1", req_ready[1]); end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL bp_ready_n%0d: got %b want 0", k, req_ready[1]); end
            checks++; if (resp_valid[1] !== (k == 4)) begin errors++; $display("FAIL bp_valid_n%0d: got %b want %b", k, resp_valid[1], k == 4); end
        end
        first_d = resp_data[1];
        checks++; if (first_d !== d_exp) begin errors++; $display("FAIL bp_data: got %h want %h", first_d, d_exp); end
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_wdata[1] = ~d_exp; req_funct3[1] = F3_W;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++; if (resp_valid[1] !== 1'b1) begin errors++; $display("FAIL bp_hold_valid%0d: got %b want 1", k, resp_valid[1]); end
            checks++; if (resp_data[1] !== first_d) begin errors++; $display("FAIL bp_hold_data%0d: got %h want %h", k, resp_data[1], first_d); end
            checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL bp_hold_ready%0d: got %b want 0", k, req_ready[1]); end
        end
        req_valid[1] = 1'b0;
        resp_ready[1] = 1'b1;
        @(posedge clk); #1;
        resp_ready[1] = 1'b0;
        checks++; if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", req_ready[1]); end
        checks++; if (resp_valid[1] !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", resp_valid[1]); end
        xact(1, 0, 32'h30, 32'h0, F3_W, d_got, f_got, lat);
        checks++; if (d_got !== d_exp) begin errors++; $display("FAIL bp_no_second_store: got %h want %h", d_got, d_exp); end
    endtask

    task automatic test_random();
        logic [31:0] d_got, d_exp, addr, wdata;
        logic        f_got, f_exp;
        logic [2:0]  f3;
        bit          wr;
        int          lat;
        logic [2:0]  legal_f3 [5];
        legal_f3 = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 40; n++) begin
                wr    = 1'($urandom_range(0, 1));
                f3    = ($urandom_range(0, 9) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)];
                addr  = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(4*DEPTH, 4*DEPTH + 12))
                                                     : 32'($urandom_range(0, 4*DEPTH - 1));
                wdata = $urandom;
                model(d, wr, addr, wdata, f3, d_exp, f_exp);
                xact(d, wr, addr, wdata, f3, d_got, f_got, lat);
                checks++; if (lat !== lat_of(d)) begin errors++; $display("FAIL rnd_latency[%0d] op%0d: got %0d want %0d", d, n, lat, lat_of(d)); end
                checks++; if (f_got !== f_exp) begin errors++; $display("FAIL rnd_fault[%0d] op%0d a=%h f3=%0d wr=%0d: got %b want %b", d, n, addr, f3, wr, f_got, f_exp); end
                checks++; if (d_got !== d_exp) begin errors++; $display("FAIL rnd_data[%0d] op%0d a=%h f3=%0d wr=%0d: got %h want %h", d, n, addr, f3, wr, d_got, d_exp); end
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [31:0] d_got;
        logic        f_got;
        int          lat;
        bit          seen;
        @(negedge clk);
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h40;
        req_wdata[1] = 32'h12345678; req_funct3[1] = F3_W;
        resp_ready[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (resp_valid[1] === 1'b1) seen = 1;
        end
        resp_ready[1] = 1'b0;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midbusy_no_resp: got %b want 0", seen); end
        checks++; if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL midbusy_ready: got %b want 1", req_ready[1]); end
        xact(1, 0, 32'h40, 32'h0, F3_W, d_got, f_got, lat);
        checks++; if (d_got !== 32'h0) begin errors++; $display("FAIL midbusy_dropped_store: got %h want 0", d_got); end
        xact(0, 0, 32'h20, 32'h0, F3_W, d_got, f_got, lat);
        checks++; if (d_got !== 32'h0) begin errors++; $display("FAIL reset_clears_l1: got %h want 0", d_got); end
        xact(1, 0, 32'h30, 32'h0, F3_W, d_got, f_got, lat);
        checks++; if (d_got !== 32'h0) begin errors++; $display("FAIL reset_clears_l4: got %h want 0", d_got); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0; req_funct3[d] = '0; resp_ready[d] = 1'b0;
        end
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        test_reset();
        test_word_l1();
        test_steering();
        test_faults();
        test_backpressure();
        test_random();
        test_reset_mid_busy();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
